// File: rtl/lsu_mem_if_if.sv
// Signal bundle between the LSU, the lsu_mem_if bridge and the memory bus.
// slave is the bridge's view; master is the environment driving LSU requests and bus replies.
interface lsu_mem_if_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wen;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wmask;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_bus_valid;
  logic        i_bus_ready;
  logic [31:0] o_bus_addr;
  logic        o_bus_wen;
  logic [63:0] o_bus_wdata;
  logic [7:0]  o_bus_wstrb;
  logic        i_bus_rvalid;
  logic [63:0] i_bus_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_wen, i_req_wdata, i_req_wmask,
    input  i_bus_ready, i_bus_rvalid, i_bus_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_bus_valid, o_bus_addr, o_bus_wen, o_bus_wdata, o_bus_wstrb
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_wen, i_req_wdata, i_req_wmask,
    output i_bus_ready, i_bus_rvalid, i_bus_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_bus_valid, o_bus_addr, o_bus_wen, o_bus_wdata, o_bus_wstrb
  );
endinterface

// File: rtl/lsu_mem_if.sv
// Single-outstanding bridge from LSU load/store requests to a 64-bit memory bus,
// with address-window checking and a completion timeout.
module lsu_mem_if #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0008_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_mem_if_if.slave bus,
  output logic [1:0] dbg_state
);

  // Handshakes: a request transfers on a cycle where i_req_valid && o_req_ready; a bus
  // request transfers where o_bus_valid && i_bus_ready, with fields held until then;
  // i_bus_rvalid completes it; o_rsp_valid is a single-cycle pulse with no backpressure.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [32:0] LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE} - 33'd1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:3]        addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [7:0]         wmask_q, wmask_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               in_range;

  assign in_range = ({1'b0, bus.i_req_addr} >= LO) && ({1'b0, bus.i_req_addr} <= HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          addr_d  = bus.i_req_addr[31:3];
          wen_d   = bus.i_req_wen;
          wdata_d = bus.i_req_wdata;
          wmask_d = bus.i_req_wmask;
          rdata_d = 64'd0;
          err_d   = !in_range;
          state_d = in_range ? REQ : RESP;
        end
      end
      REQ: begin
        if (bus.i_bus_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A completion arriving on the final timeout cycle still counts as success.
        if (bus.i_bus_rvalid) begin
          state_d = RESP;
          rdata_d = wen_q ? 64'd0 : bus.i_bus_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = 64'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus and response fields are forced to zero outside the state that presents them.
  always_comb begin
    bus.o_req_ready = (state_q == IDLE);
    bus.o_rsp_valid = (state_q == RESP);
    bus.o_rsp_rdata = (state_q == RESP) ? rdata_q : 64'd0;
    bus.o_rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    bus.o_bus_valid = (state_q == REQ);
    bus.o_bus_addr  = (state_q == REQ) ? {addr_q, 3'b000} : 32'd0;
    bus.o_bus_wen   = (state_q == REQ) ? wen_q : 1'b0;
    bus.o_bus_wdata = (state_q == REQ) ? wdata_q : 64'd0;
    bus.o_bus_wstrb = (state_q == REQ && wen_q) ? wmask_q : 8'd0;
  end

  assign dbg_state = state_q;

endmodule

// File: doc/lsu_mem_if.md
LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h8000_0000, lowest legal byte address.
REQ-002 SHALL have parameter ADDR_SIZE, default 32'h0008_0000, legal window size in bytes (64K x 64-bit words).
REQ-003 SHALL have parameter TIMEOUT, default 16, number of WAIT cycles before an error response.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  1  LSU request present.
REQ-007 SHALL have port o_req_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port i_req_addr  input  32  byte address.
REQ-009 SHALL have port i_req_wen  input  1  1 = store, 0 = load.
REQ-010 SHALL have port i_req_wdata  input  64  store data, already lane-positioned.
REQ-011 SHALL have port i_req_wmask  input  8  byte-lane write enables, ignored for loads.
REQ-012 SHALL have port o_rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port o_rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-014 SHALL have port o_rsp_err  output  1  response is an error (out of range or timeout).
REQ-015 SHALL have port o_bus_valid  output  1  bus request.
REQ-016 SHALL have port i_bus_ready  input  1  bus accepts request.
REQ-017 SHALL have port o_bus_addr  output  32  {latched addr[31:3], 3'b000}.
REQ-018 SHALL have port o_bus_wen, o_bus_wdata, o_bus_wstrb  output  1/64/8  latched store fields; wstrb = 8'h00 for loads.
REQ-019 SHALL have port i_bus_rvalid  input  1  bus completion (load data or store acknowledge).
REQ-020 SHALL have port i_bus_rdata  input  64  load data, valid with i_bus_rvalid.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, RESP; o_req_ready = 1 only in IDLE.
REQ-022 IDLE: on i_req_valid, SHALL latch addr/wen/wdata/wmask; in range -> REQ, else -> RESP with err=1.
REQ-023 In range SHALL mean ADDR_BASE <= addr <= ADDR_BASE+ADDR_SIZE-1, compared unsigned in 33 bits (no wrap).
REQ-024 REQ: o_bus_valid=1 with latched fields held stable; on i_bus_ready -> WAIT, timeout counter cleared to 0.
REQ-025 WAIT: o_bus_valid=0; i_bus_rvalid -> RESP, capturing i_bus_rdata for loads (0 for stores), err=0.
REQ-026 WAIT: counter increments each cycle without rvalid; counter == TIMEOUT-1 without rvalid -> RESP with err=1, rdata=0.
REQ-027 rvalid in the same cycle as the timeout condition SHALL win (normal response, err=0).
REQ-028 i_bus_rvalid outside WAIT SHALL be ignored; i_bus_ready outside REQ SHALL be ignored.
REQ-029 RESP: o_rsp_valid=1 for exactly one cycle, with o_rsp_rdata/o_rsp_err stable; then -> IDLE; no backpressure.
REQ-030 Minimum in-range latency SHALL be 3 cycles from accept to o_rsp_valid (ready in first REQ cycle, rvalid in first WAIT cycle).
REQ-031 Out-of-range latency SHALL be 1 cycle from accept to o_rsp_valid; no bus request is issued.
REQ-032 Exactly one outstanding transaction; a new request SHALL NOT be accepted until the cycle after RESP.
REQ-033 o_rsp_rdata and o_rsp_err SHALL be 0 whenever o_rsp_valid=0.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, counter=0, all latched fields=0.
REQ-035 During and after reset: o_req_ready=1, all other outputs 0.
REQ-036 Reset mid-transaction SHALL abandon it: no response issued, and a later i_bus_rvalid is ignored.

Verification
REQ-037 Load 0x8000_0010, ready in REQ cycle 1, rvalid+rdata 64'h1122_3344_5566_7788 in WAIT cycle 1 -> o_bus_addr 0x8000_0010, wstrb 0; rsp 3 cycles after accept, rdata 64'h1122..7788, err 0.
REQ-038 Store 0x8000_0006, wmask 8'hC0, wdata 64'hAB00_0000_0000_0000 -> o_bus_addr 0x8000_0000, wstrb 8'hC0, wen 1; after rvalid, rsp rdata 0, err 0.
REQ-039 Load 0x7FFF_FFF8 and load 0x8008_0000 -> no o_bus_valid; rsp 1 cycle after accept, err 1.
REQ-040 Load, ready held 0 for 5 cycles -> o_bus_valid stays 1 with stable fields; o_req_ready 0 throughout.
REQ-041 Load, no rvalid (TIMEOUT=16) -> rsp err 1, rdata 0 after 16 WAIT cycles; repeat with rvalid on the 16th WAIT cycle -> err 0, data returned.
REQ-042 rst_n low for 1 cycle while in WAIT, then rvalid -> no o_rsp_valid; o_req_ready 1 after reset.
